serial_deser: RTL and testbench
===============================

# serial_deser

Serial-to-parallel receiver for the bit streams produced by the parametrized universal shift register's serial outputs. It frames a serial bit stream on a start-of-frame strobe and assembles N-bit words in either bit order. Completed words go to a one-entry output buffer with a valid/ready handshake. Overflow and framing errors are flagged in sticky status bits.

## Interface
- N, default 4: word width in bits; legal range N >= 2.
- CNT_W, default $clog2(N+1): bit-counter width; derived, not overridden.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- din  in  1  serial data bit; sampled only when din_valid=1.
- din_valid  in  1  din carries a bit this cycle.
- sof  in  1  start of frame; qualifies the first bit and is ignored unless din_valid=1.
- dir  in  1  bit order, sampled with the sof bit: 0 = LSB first, 1 = MSB first.
- word  out  N  assembled word; stable while word_valid=1.
- word_valid  out  1  output buffer holds a word.
- word_ready  in  1  consumer accepts the word.
- busy  out  1  a frame is in progress (state != IDLE).
- overflow  out  1  sticky: a completed word was dropped because the buffer was full.
- frame_err  out  1  sticky: a frame restarted early, or a parity check failed.
- clr_status  in  1  clears overflow and frame_err.

## Operation
- Reset: state IDLE, shift reg/counter 0, word=0, word_valid=0, busy=0, overflow=0, frame_err=0. The same applies to reset mid-frame: the partial word is discarded and no word is emitted.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE behaviour:
  - din_valid and sof: latch dir, capture bit 0, cnt=1, go to SHIFT.
  - din_valid without sof: the bit is ignored.
- SHIFT behaviour:
  - Each din_valid: capture bit, cnt+1.
  - din_valid=0: hold all state; gaps of any length are allowed.
- Assembly rules:
  - LSB first: sh <= {din, sh[N-1:1]}; the first bit ends in word[0].
  - MSB first: sh <= {sh[N-2:0], din}; the first bit ends in word[N-1].
- Completion on the Nth bit:
  - Without the macro: deliver the word and go to IDLE.
  - With the macro: go to PARITY.
- sof with din_valid while in SHIFT or PARITY: set frame_err, discard the partial word, treat the bit as bit 0 of a new frame (dir re-latched, cnt=1, state SHIFT).
- Delivery:
  - Buffer empty, or popped the same cycle (word_valid && word_ready): load the word; word_valid=1.
  - Buffer full and not popped: drop the new word, set overflow, keep the old word.
- Pop: word_valid && word_ready at a clock edge; word_valid falls unless a new word loads in the same edge.
- Status: clr_status clears both flags. A set and a clear in the same cycle leaves the flag set.

## Timing
- word_valid rises on the edge after the edge that samples the last bit (the Nth data bit, or the parity bit with the macro). Latency is 1 cycle.
- Back-to-back frames: sof is legal in the cycle immediately after a frame's last bit, so there are zero dead cycles.
- Throughput: one bit per cycle, giving one word per N cycles (N+1 with parity).
- word_ready has no combinational path to any output; all outputs are registered.
- busy is registered and reflects the state after each edge.

## Configuration
- SERIAL_DESER_PARITY_EN defined:
  - After the N data bits, the next din_valid bit is an even-parity bit: XOR of the data bits and the parity bit must be 0.
  - On match, deliver the word.
  - On mismatch, drop the word and set frame_err.
  - Return to IDLE either way.
- Not defined: the PARITY state and its logic are absent; a frame is exactly N bits.

## Structure
- Package serial_deser_pkg holds:
  - state enum (IDLE, SHIFT, PARITY);
  - DIR_LSB=1'b0 and DIR_MSB=1'b1.
- Sub-module deser_out_buf: the one-entry buffer with the valid/ready handshake and overflow detect (ports: load, data_in, word, word_valid, word_ready, drop).

## Test plan
- LSB-first frame, N=4, word_ready=1: sof+bits 1,0,1,1 on consecutive cycles -> word=4'b1101, word_valid high one cycle after the 4th bit.
- MSB-first frame: same bits with dir=1 -> word=4'b1011. Then insert 3-cycle din_valid gaps mid-frame -> same result, busy held high.
- word_ready=0, two back-to-back frames (1101 then 0110) -> word stays 4'b1101, overflow=1. Raise word_ready for one cycle -> word_valid falls. Pulse clr_status -> overflow=0.
- sof asserted again on the 3rd bit, then 3 more bits 0,0,1 -> frame_err=1, word=4'b1000 (LSB first).
- reset_n low for one cycle after 2 bits, then a clean frame 0,1,1,1 -> no word from the aborted frame, next word=4'b1110, all flags 0.
- With SERIAL_DESER_PARITY_EN: bits 1,1,0,1 plus parity 1 -> word 4'b1011 delivered. The same bits plus parity 0 -> no word_valid, frame_err=1.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// serial_deser_pkg: frame state encoding and bit-order constants shared by serial_deser.
package serial_deser_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;
endpackage

// File: rtl/deser_out_buf.sv
// deser_out_buf: one-entry word buffer with valid/ready handshake; drop flags a load into a full, unpopped buffer.
module deser_out_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] word,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         drop
);
    logic [N-1:0] word_q, word_d;
    logic         valid_q, valid_d;

    always_comb begin
        drop    = load && valid_q && !word_ready;
        word_d  = (load && !drop) ? data_in : word_q;
        valid_d = (load && !drop) || (valid_q && !word_ready);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
endmodule

// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel receiver framed by sof, LSB- or MSB-first, with sticky overflow/frame_err.
// Define SERIAL_DESER_PARITY_EN to require a trailing even-parity bit per frame.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         din,
    input  logic         din_valid,
    input  logic         sof,
    input  logic         dir,
    output logic [N-1:0] word,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         busy,
    output logic         overflow,
    output logic         frame_err,
    input  logic         clr_status
);
    localparam int CNT_W = $clog2(N + 1);

    state_e           state_q, state_d;
    logic [N-1:0]     sh_q, sh_d, data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d, load_q, load_d;
    logic             overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic             fe_set, drop;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] sh, input logic b, input logic d);
        return (d == DIR_MSB) ? {sh[N-2:0], b} : {b, sh[N-1:1]};
    endfunction

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        load_d  = 1'b0;
        fe_set  = 1'b0;
        if (din_valid) begin
            if (sof) begin
                fe_set  = state_q != IDLE;
                state_d = SHIFT;
                dir_d   = dir;
                sh_d    = shift_in('0, din, dir);
                cnt_d   = CNT_W'(1);
            end else if (state_q == SHIFT) begin
                sh_d  = shift_in(sh_q, din, dir_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    cnt_d   = '0;
                    load_d  = 1'b1;
`endif
                end
`ifdef SERIAL_DESER_PARITY_EN
            end else if (state_q == PARITY) begin
                state_d = IDLE;
                cnt_d   = '0;
                load_d  = ~(^sh_q ^ din);
                fe_set  = ^sh_q ^ din;
`endif
            end
        end
        data_d      = sh_d;
        overflow_d  = drop || (overflow_q && !clr_status);
        frame_err_d = fe_set || (frame_err_q && !clr_status);
    end

    // The completed word waits one cycle here, so delivery lands on the edge after the last bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_LSB;
            load_q      <= 1'b0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            load_q      <= load_d;
            data_q      <= data_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    deser_out_buf #(.N(N)) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_q),
        .data_in    (data_q),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .drop       (drop)
    );

    assign busy      = state_q != IDLE;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: randomized self-checking bench for serial_deser (N=4) against a bit-order reference model.
module tb_serial_deser;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         din = 1'b0, din_valid = 1'b0, sof = 1'b0, dir = 1'b0;
    logic [N-1:0] word;
    logic         word_valid, word_ready = 1'b1, busy, overflow, frame_err;
    logic         clr_status = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;

    serial_deser #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .dir        (dir),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    // seq[i] is the i-th bit sent on the wire
    function automatic logic [N-1:0] model(input logic [N-1:0] seq, input logic d);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) w[d ? N - 1 - i : i] = seq[i];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic b, input logic s, input logic d);
        din = b; sof = s; dir = d; din_valid = 1'b1;
        tick();
        din_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic idle_gap(input int gap);
        for (int g = 0; g < gap; g++) begin
            n_chk++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: busy=%b want 1", busy); end
            tick();
        end
    endtask

    task automatic send_frame(input logic [N-1:0] seq, input logic d, input int gap);
        for (int i = 0; i < N; i++) begin
            step(seq[i], i == 0, d);
            if (i < N - 1) idle_gap(gap);
        end
`ifdef SERIAL_DESER_PARITY_EN
        idle_gap(gap);
        step(^seq, 1'b0, d);
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        n_chk++;
        if ({word, word_valid, busy, overflow, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset: word=%b v=%b busy=%b ovf=%b fe=%b want all 0", word, word_valid, busy, overflow, frame_err);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lsb();
        send_frame(4'b1101, 1'b0, 0);
        n_chk++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_latency: word_valid=%b want 0", word_valid); end
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1101) begin
            n_fail++; $display("FAIL lsb_word: v=%b word=%b want v=1 word=1101", word_valid, word);
        end
        tick();
        n_chk++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_pop: word_valid=%b want 0", word_valid); end
    endtask

    task automatic test_msb_gaps();
        send_frame(4'b1101, 1'b1, 0);
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1011) begin
            n_fail++; $display("FAIL msb_word: v=%b word=%b want v=1 word=1011", word_valid, word);
        end
        tick();
        send_frame(4'b1101, 1'b1, 3);
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1011) begin
            n_fail++; $display("FAIL msb_gap_word: v=%b word=%b want v=1 word=1011", word_valid, word);
        end
        tick();
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        send_frame(4'b1101, 1'b0, 0);
        send_frame(4'b0110, 1'b0, 0);
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1101 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_keep: v=%b word=%b ovf=%b want v=1 word=1101 ovf=1", word_valid, word, overflow);
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        n_chk++;
        if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_pop: v=%b ovf=%b want v=0 ovf=1", word_valid, overflow);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_chk++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", overflow); end
        word_ready = 1'b1;
    endtask

    task automatic test_restart();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (frame_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_fe: fe=%b busy=%b want 1 1", frame_err, busy);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
`ifdef SERIAL_DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b0);
`endif
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1000) begin
            n_fail++; $display("FAIL restart_word: v=%b word=%b want v=1 word=1000", word_valid, word);
        end
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_chk++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL fe_clear: fe=%b want 0", frame_err); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_chk++;
        if (busy !== 1'b0 || word_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort: busy=%b v=%b want 0 0", busy, word_valid);
        end
        send_frame(4'b1110, 1'b0, 0);
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1110 || overflow !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL after_abort: v=%b word=%b ovf=%b fe=%b want 1 1110 0 0", word_valid, word, overflow, frame_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] a, b;
            logic         da, db;
            a = N'($urandom); b = N'($urandom);
            da = 1'($urandom); db = 1'($urandom);
            send_frame(a, da, 0);
            step(b[0], 1'b1, db);
            n_chk++;
            if (word_valid !== 1'b1 || word !== model(a, da)) begin
                n_fail++; $display("FAIL b2b_first: v=%b word=%b want v=1 word=%b", word_valid, word, model(a, da));
            end
            for (int i = 1; i < N; i++) step(b[i], 1'b0, db);
`ifdef SERIAL_DESER_PARITY_EN
            step(^b, 1'b0, db);
`endif
            tick();
            n_chk++;
            if (word_valid !== 1'b1 || word !== model(b, db)) begin
                n_fail++; $display("FAIL b2b_second: v=%b word=%b want v=1 word=%b", word_valid, word, model(b, db));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            logic [N-1:0] s;
            logic         d;
            s = N'($urandom);
            d = 1'($urandom);
            send_frame(s, d, $urandom_range(0, 2));
            tick();
            n_chk++;
            if (word_valid !== 1'b1 || word !== model(s, d) || frame_err !== 1'b0 || overflow !== 1'b0) begin
                n_fail++; $display("FAIL random: seq=%b dir=%b v=%b word=%b want %b", s, d, word_valid, word, model(s, d));
            end
            tick();
        end
    endtask

`ifdef SERIAL_DESER_PARITY_EN
    task automatic test_parity();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        tick();
        n_chk++;
        if (word_valid !== 1'b1 || word !== 4'b1011 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL parity_ok: v=%b word=%b fe=%b want 1 1011 0", word_valid, word, frame_err);
        end
        tick();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        tick();
        n_chk++;
        if (word_valid !== 1'b0 || frame_err !== 1'b1) begin
            n_fail++; $display("FAIL parity_bad: v=%b fe=%b want 0 1", word_valid, frame_err);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_lsb();
        test_msb_gaps();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SERIAL_DESER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
